// File: rtl/tsu_queue_rdr.sv
// Drains one tsu timestamp queue into a staging register and serves it as host-sized words.
// Optional interrupt output is enabled with `define TSU_QRD_IRQ_EN.
module tsu_queue_rdr #(
  parameter int unsigned Q_DW    = 128,
  parameter int unsigned HOST_DW = 32,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned AW      = $clog2(WORDS)
) (
  input  logic               q_rd_clk,
  input  logic               rst,
  output logic               q_rd_en,
  input  logic [7:0]         q_rd_stat,
  input  logic [Q_DW-1:0]    q_rd_data,
  input  logic               host_rd_en,
  input  logic [AW-1:0]      host_rd_addr,
  output logic [HOST_DW-1:0] host_rd_data,
  input  logic               flush,
  output logic               ts_valid,
`ifdef TSU_QRD_IRQ_EN
  input  logic               irq_mask,
  output logic               irq,
`endif
  output logic [CNT_W-1:0]   ts_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e             state_q, state_d;
  logic               q_rd_en_q, q_rd_en_d;
  logic [Q_DW-1:0]    hold_q, hold_d;
  logic               ts_valid_q, ts_valid_d;
  logic [CNT_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic [HOST_DW-1:0] host_rd_data_q, host_rd_data_d;
  logic [HOST_DW-1:0] rd_word;
  logic               drain_done;

  // Word 0 is the most significant slice of the entry.
  always_comb begin
    rd_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (host_rd_addr == AW'(w)) rd_word = hold_q[Q_DW-1-w*HOST_DW -: HOST_DW];
    end
  end

  assign drain_done = (state_q == StHold) && host_rd_en && (host_rd_addr == AW'(WORDS-1));

  always_comb begin
    state_d        = state_q;
    q_rd_en_d      = 1'b0;
    hold_d         = hold_q;
    ts_valid_d     = ts_valid_q;
    ts_cnt_d       = ts_cnt_q;
    host_rd_data_d = host_rd_data_q;

    if (host_rd_en) host_rd_data_d = ts_valid_q ? rd_word : '0;

    unique case (state_q)
      StIdle: begin
        if (q_rd_stat != 8'd0) begin
          q_rd_en_d = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        hold_d     = q_rd_data;
        ts_valid_d = 1'b1;
        ts_cnt_d   = ts_cnt_q + CNT_W'(1);
        state_d    = StHold;
      end
      StHold: begin
        if (drain_done) begin
          ts_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides everything except the count of an entry already popped.
    if (flush) begin
      hold_d     = '0;
      ts_valid_d = 1'b0;
      q_rd_en_d  = 1'b0;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge q_rd_clk) begin
    if (rst) begin
      state_q        <= StIdle;
      q_rd_en_q      <= 1'b0;
      hold_q         <= '0;
      ts_valid_q     <= 1'b0;
      ts_cnt_q       <= '0;
      host_rd_data_q <= '0;
    end else begin
      state_q        <= state_d;
      q_rd_en_q      <= q_rd_en_d;
      hold_q         <= hold_d;
      ts_valid_q     <= ts_valid_d;
      ts_cnt_q       <= ts_cnt_d;
      host_rd_data_q <= host_rd_data_d;
    end
  end

  assign q_rd_en      = q_rd_en_q;
  assign ts_valid     = ts_valid_q;
  assign ts_cnt       = ts_cnt_q;
  assign host_rd_data = host_rd_data_q;

`ifdef TSU_QRD_IRQ_EN
  logic irq_q;

  always_ff @(posedge q_rd_clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= ts_valid_q & ~irq_mask;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_tsu_queue_rdr.sv
// Directed bench for tsu_queue_rdr; inputs change and outputs are checked on the falling edge.
module tb_tsu_queue_rdr;

  logic         q_rd_clk;
  logic         rst;
  logic         q_rd_en;
  logic [7:0]   q_rd_stat;
  logic [127:0] q_rd_data;
  logic         host_rd_en;
  logic [1:0]   host_rd_addr;
  logic [31:0]  host_rd_data;
  logic         flush;
  logic         ts_valid;
  logic [15:0]  ts_cnt;
`ifdef TSU_QRD_IRQ_EN
  logic         irq_mask;
  logic         irq;
`endif

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int overlap = 0;

  tsu_queue_rdr dut (
    .q_rd_clk     (q_rd_clk),
    .rst          (rst),
    .q_rd_en      (q_rd_en),
    .q_rd_stat    (q_rd_stat),
    .q_rd_data    (q_rd_data),
    .host_rd_en   (host_rd_en),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .flush        (flush),
    .ts_valid     (ts_valid),
`ifdef TSU_QRD_IRQ_EN
    .irq_mask     (irq_mask),
    .irq          (irq),
`endif
    .ts_cnt       (ts_cnt)
  );

  initial q_rd_clk = 1'b0;
  always #5 q_rd_clk = ~q_rd_clk;

  // Pop and overlap monitors sample pre-edge values.
  always @(posedge q_rd_clk) begin
    if (!rst && q_rd_en) pops++;
    if (!rst && q_rd_en && ts_valid) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge q_rd_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] ent;
  int pops0;

  initial begin
    rst = 1'b1; q_rd_stat = 8'd0; q_rd_data = '0; host_rd_en = 1'b0;
    host_rd_addr = 2'd0; flush = 1'b0;
`ifdef TSU_QRD_IRQ_EN
    irq_mask = 1'b0;
`endif
    // 1. reset and idle
    tick(); tick();
    chk("rst_q_rd_en", 32'(q_rd_en), 32'd0);
    chk("rst_ts_valid", 32'(ts_valid), 32'd0);
    chk("rst_ts_cnt", 32'(ts_cnt), 32'd0);
    chk("rst_host_rd_data", host_rd_data, 32'd0);
`ifdef TSU_QRD_IRQ_EN
    chk("rst_irq", 32'(irq), 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_no_pop", 32'(q_rd_en), 32'd0);
    end

    // 2. single entry, word order MSW first
    q_rd_stat = 8'd1;
    q_rd_data = 128'h01234567_0BADF00D_DEADBEEF_89ABCDEF;
    tick();
    chk("t2_pop", 32'(q_rd_en), 32'd1);
    chk("t2_valid_early", 32'(ts_valid), 32'd0);
    q_rd_stat = 8'd0;
    tick();
    chk("t2_pop_once", 32'(q_rd_en), 32'd0);
    chk("t2_valid", 32'(ts_valid), 32'd1);
    chk("t2_cnt", 32'(ts_cnt), 32'd1);
    host_rd_en = 1'b1;
    host_rd_addr = 2'd0; tick(); chk("t2_w0", host_rd_data, 32'h01234567);
    chk("t2_valid_w0", 32'(ts_valid), 32'd1);
    host_rd_addr = 2'd1; tick(); chk("t2_w1", host_rd_data, 32'h0BADF00D);
    host_rd_addr = 2'd2; tick(); chk("t2_w2", host_rd_data, 32'hDEADBEEF);
    chk("t2_valid_w2", 32'(ts_valid), 32'd1);
    host_rd_addr = 2'd3; tick(); chk("t2_w3", host_rd_data, 32'h89ABCDEF);
    chk("t2_released", 32'(ts_valid), 32'd0);
    host_rd_en = 1'b0;
    tick();
    chk("t2_no_repop", 32'(q_rd_en), 32'd0);

    // 3. five entries with stat held at 5
    rst = 1'b1; tick(); rst = 1'b0;
    pops0 = pops;
    q_rd_stat = 8'd5;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) ent[127-32*k -: 32] = 32'hA000_0000 + 32'(i*16 + k);
      q_rd_data = ent;
      tick();
      chk("t3_pop", 32'(q_rd_en), 32'd1);
      tick();
      chk("t3_valid", 32'(ts_valid), 32'd1);
      chk("t3_pop_pulse", 32'(q_rd_en), 32'd0);
      host_rd_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        host_rd_addr = 2'(k);
        tick();
        chk("t3_word", host_rd_data, 32'hA000_0000 + 32'(i*16 + k));
        chk("t3_no_pop_in_hold", 32'(q_rd_en), 32'd0);
      end
      chk("t3_released", 32'(ts_valid), 32'd0);
      host_rd_en = 1'b0;
      if (i == 4) q_rd_stat = 8'd0;
    end
    tick();
    chk("t3_pop_count", 32'(pops - pops0), 32'd5);
    chk("t3_cnt", 32'(ts_cnt), 32'd5);
    chk("t3_overlap", 32'(overlap), 32'd0);

    // 4. flush in wait, then flush together with release
    q_rd_stat = 8'd1;
    q_rd_data = 128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003;
    tick();
    chk("t4_pop", 32'(q_rd_en), 32'd1);
    flush = 1'b1; q_rd_stat = 8'd0;
    tick();
    chk("t4_flush_valid", 32'(ts_valid), 32'd0);
    chk("t4_flush_cnt", 32'(ts_cnt), 32'd6);
    flush = 1'b0; host_rd_en = 1'b1; host_rd_addr = 2'd0;
    tick();
    chk("t4_idle_read", host_rd_data, 32'd0);
    chk("t4_idle_valid", 32'(ts_valid), 32'd0);
    host_rd_en = 1'b0; q_rd_stat = 8'd1;
    tick();
    chk("t4_idle_again", 32'(q_rd_en), 32'd1);
    q_rd_stat = 8'd0;
    tick();
    chk("t4_valid", 32'(ts_valid), 32'd1);
    chk("t4_cnt", 32'(ts_cnt), 32'd7);
    host_rd_en = 1'b1; host_rd_addr = 2'd3; flush = 1'b1;
    tick();
    chk("t4_flush_rel_data", host_rd_data, 32'hCAFE0003);
    chk("t4_flush_rel_valid", 32'(ts_valid), 32'd0);
    host_rd_en = 1'b0; flush = 1'b0;
    tick();
    chk("t4_no_pop", 32'(q_rd_en), 32'd0);

    // 5. counter wrap
    force dut.ts_cnt_q = 16'hFFFF;
    tick();
    release dut.ts_cnt_q;
    chk("t5_preload", 32'(ts_cnt), 32'h0000FFFF);
    q_rd_stat = 8'd1;
    tick();
    q_rd_stat = 8'd0;
    tick();
    chk("t5_wrap", 32'(ts_cnt), 32'd0);
    chk("t5_valid", 32'(ts_valid), 32'd1);
    host_rd_en = 1'b1; host_rd_addr = 2'd3;
    tick();
    chk("t5_released", 32'(ts_valid), 32'd0);
    host_rd_en = 1'b0;
    tick();

`ifdef TSU_QRD_IRQ_EN
    // 6. interrupt follows ts_valid by one cycle, masked stays low
    irq_mask = 1'b0; q_rd_stat = 8'd1;
    tick();
    q_rd_stat = 8'd0;
    tick();
    chk("t6_valid", 32'(ts_valid), 32'd1);
    chk("t6_irq_lag", 32'(irq), 32'd0);
    tick();
    chk("t6_irq_rise", 32'(irq), 32'd1);
    host_rd_en = 1'b1; host_rd_addr = 2'd3;
    tick();
    host_rd_en = 1'b0;
    chk("t6_irq_hold", 32'(irq), 32'd1);
    tick();
    chk("t6_irq_fall", 32'(irq), 32'd0);
    irq_mask = 1'b1; q_rd_stat = 8'd1;
    tick();
    q_rd_stat = 8'd0;
    tick(); tick();
    chk("t6_masked_valid", 32'(ts_valid), 32'd1);
    chk("t6_masked_irq", 32'(irq), 32'd0);
    irq_mask = 1'b0;
    tick();
    chk("t6_unmask_irq", 32'(irq), 32'd1);
    host_rd_en = 1'b1; host_rd_addr = 2'd3;
    tick();
    host_rd_en = 1'b0;
    tick();
    chk("t6_final_irq", 32'(irq), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
